// File: rtl/ram_write_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ram_write_port_arb (with payload package)
//  Purpose  : Per-bank write-port arbiter. Buffers the four directional write
//             commands in small FIFOs and round-robins them onto a single
//             RAM write port, returning one credit per drained entry.
//  Revision : 1.0 - initial release
// ============================================================================

package ram_write_port_arb_pkg;
    typedef struct packed {
        logic [3:0] dest_ram_id;
        logic [7:0] addr;
    } req_cmd_pld_t;

    typedef struct packed {
        req_cmd_pld_t req_cmd_pld;
        logic [15:0]  data;
    } write_cmd_t;

    typedef struct packed {
        logic       linefill;
        write_cmd_t write_cmd;
    } write_ram_pld_t;
endpackage

module ram_write_port_arb
    import ram_write_port_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit RAM_PARITY = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           west_wr_vld,
    input  write_ram_pld_t west_wr_pld,
    input  logic           east_wr_vld,
    input  write_ram_pld_t east_wr_pld,
    input  logic           south_wr_vld,
    input  write_ram_pld_t south_wr_pld,
    input  logic           north_wr_vld,
    input  write_ram_pld_t north_wr_pld,
    output logic           ram_wr_en,
    output write_ram_pld_t ram_wr_pld,
    input  logic           ram_wr_ready,
    output logic [3:0]     credit_ret,
    output logic [3:0]     ovf_err,
    output logic           route_err,
    output logic           idle
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_AW + 1;

    // Channel order everywhere: 0 = west, 1 = east, 2 = south, 3 = north
    logic [3:0]     w_vld;
    write_ram_pld_t w_pld  [4];
    write_ram_pld_t w_head [4];
    logic [3:0]     w_par_err;
    logic [3:0]     w_full;
    logic [3:0]     w_push;
    logic [3:0]     w_ovf_set;
    logic [3:0]     w_nempty;
    logic [3:0]     w_pop;
    logic [3:0]     w_cnt_zero;

    logic           w_load_en;
    logic           w_gnt_vld;
    logic [1:0]     w_gnt;

    logic           r_en;
    write_ram_pld_t r_pld;
    logic [1:0]     r_ptr;
    logic [3:0]     r_credit;
    logic [3:0]     r_ovf;
    logic           r_route;

    assign w_vld     = {north_wr_vld, south_wr_vld, east_wr_vld, west_wr_vld};
    assign w_pld[0]  = west_wr_pld;
    assign w_pld[1]  = east_wr_pld;
    assign w_pld[2]  = south_wr_pld;
    assign w_pld[3]  = north_wr_pld;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_ch
            logic [c_CW-1:0] r_cnt;
            logic [c_AW-1:0] r_wp;
            logic [c_AW-1:0] r_rp;
            write_ram_pld_t  r_mem [FIFO_DEPTH];

            // A misrouted command is never queued; it only returns its credit.
            // Fullness is judged on the pre-edge count, so a same-cycle pop
            // does not make room for a push into a full FIFO.
            assign w_par_err[i]  = w_vld[i] &&
                                   (w_pld[i].write_cmd.req_cmd_pld.dest_ram_id[0] != RAM_PARITY);
            assign w_full[i]     = (r_cnt == c_CW'(FIFO_DEPTH));
            assign w_push[i]     = w_vld[i] && !w_par_err[i] && !w_full[i];
            assign w_ovf_set[i]  = w_vld[i] && !w_par_err[i] &&  w_full[i];
            assign w_nempty[i]   = (r_cnt != '0);
            assign w_cnt_zero[i] = (r_cnt == '0);
            assign w_head[i]     = r_mem[r_rp];

            // FIFO pointers and occupancy
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_wp  <= '0;
                    r_rp  <= '0;
                end else begin
                    if (w_push[i]) r_wp <= r_wp + c_AW'(1);
                    if (w_pop[i])  r_rp <= r_rp + c_AW'(1);
                    case ({w_push[i], w_pop[i]})
                        2'b10:   r_cnt <= r_cnt + c_CW'(1);
                        2'b01:   r_cnt <= r_cnt - c_CW'(1);
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            // FIFO storage; contents are don't-care while the count is zero
            always_ff @(posedge clk) begin
                if (w_push[i]) r_mem[r_wp] <= w_pld[i];
            end
        end
    endgenerate

    assign w_load_en = !r_en || ram_wr_ready;

    // Round-robin pick: first non-empty channel at or after the pointer
    always_comb begin
        logic [1:0] w_idx;
        w_gnt_vld = 1'b0;
        w_gnt     = r_ptr;
        w_idx     = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_gnt_vld && w_nempty[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    assign w_pop = (w_load_en && w_gnt_vld) ? (4'b0001 << w_gnt) : 4'b0000;

    // Output register and round-robin pointer; both freeze while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en  <= 1'b0;
            r_pld <= '0;
            r_ptr <= 2'd0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_en  <= 1'b1;
                r_pld <= w_head[w_gnt];
                r_ptr <= w_gnt + 2'd1;
            end else begin
                r_en  <= 1'b0;
            end
        end
    end

    // Credit pulses (pops and misroutes) and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit <= 4'b0000;
            r_ovf    <= 4'b0000;
            r_route  <= 1'b0;
        end else begin
            r_credit <= w_pop | w_par_err;
            r_ovf    <= r_ovf | w_ovf_set;
            r_route  <= r_route | (|w_par_err);
        end
    end

    assign ram_wr_en  = r_en;
    assign ram_wr_pld = r_pld;
    assign credit_ret = r_credit;
    assign ovf_err    = r_ovf;
    assign route_err  = r_route;
    assign idle       = (&w_cnt_zero) && !r_en;

endmodule
`default_nettype wire

// File: tb/tb_ram_write_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_write_port_arb
//  Purpose  : Self-checking bench for ram_write_port_arb: directed table,
//             hand-written corner sequences and randomized traffic against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_write_port_arb;
    import ram_write_port_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam bit PAR   = 1'b0;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     vld;
    write_ram_pld_t pld [4];
    logic           rdy;
    logic           ram_wr_en;
    write_ram_pld_t ram_wr_pld;
    logic [3:0]     credit_ret;
    logic [3:0]     ovf_err;
    logic           route_err;
    logic           idle;

    always #5 clk = ~clk;

    ram_write_port_arb #(.FIFO_DEPTH(DEPTH), .RAM_PARITY(PAR)) dut (
        .clk          (clk),
        .rst          (rst),
        .west_wr_vld  (vld[0]),
        .west_wr_pld  (pld[0]),
        .east_wr_vld  (vld[1]),
        .east_wr_pld  (pld[1]),
        .south_wr_vld (vld[2]),
        .south_wr_pld (pld[2]),
        .north_wr_vld (vld[3]),
        .north_wr_pld (pld[3]),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_pld   (ram_wr_pld),
        .ram_wr_ready (rdy),
        .credit_ret   (credit_ret),
        .ovf_err      (ovf_err),
        .route_err    (route_err),
        .idle         (idle)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Distinct, recognisable payload per channel/sequence; bad flips parity
    function automatic write_ram_pld_t mk_pld(input int ch, input int seq, input bit bad);
        write_ram_pld_t p;
        p.linefill                         = (ch == 2) && seq[0];
        p.write_cmd.data                   = 16'(seq * 7 + ch);
        p.write_cmd.req_cmd_pld.addr       = 8'(seq);
        p.write_cmd.req_cmd_pld.dest_ram_id = {2'(ch), 1'(seq), PAR ^ bad};
        return p;
    endfunction

    // ---------------- reference model (transaction level) ----------------
    write_ram_pld_t mq [4][$];
    logic           m_en;
    write_ram_pld_t m_pld;
    int             m_ptr;
    logic [3:0]     m_credit;
    logic [3:0]     m_ovf;
    logic           m_route;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) mq[c].delete();
        m_en = 0; m_pld = '0; m_ptr = 0; m_credit = 0; m_ovf = 0; m_route = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [3:0] cr;
        bit         found;
        int         g;
        int         sz [4];
        cr = 0; found = 0; g = 0;
        for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
        if (!m_en || rdy) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (!found && sz[c] > 0) begin found = 1; g = c; end
            end
            if (found) begin
                m_pld = mq[g].pop_front();
                m_en  = 1;
                m_ptr = (g + 1) % 4;
                cr[g] = 1;
            end else begin
                m_en = 0;
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (vld[c]) begin
                if (pld[c].write_cmd.req_cmd_pld.dest_ram_id[0] != PAR) begin
                    m_route = 1; cr[c] = 1;
                end else if (sz[c] == DEPTH) begin
                    m_ovf[c] = 1;
                end else begin
                    mq[c].push_back(pld[c]);
                end
            end
        end
        m_credit = cr;
    endtask

    task automatic compare_model(input string tag);
        bit m_idle;
        m_idle = !m_en && mq[0].size() == 0 && mq[1].size() == 0 &&
                 mq[2].size() == 0 && mq[3].size() == 0;
        check({tag, ".en"},     64'(ram_wr_en),  64'(m_en));
        if (m_en) check({tag, ".pld"}, 64'(ram_wr_pld), 64'(m_pld));
        check({tag, ".credit"}, 64'(credit_ret), 64'(m_credit));
        check({tag, ".ovf"},    64'(ovf_err),    64'(m_ovf));
        check({tag, ".route"},  64'(route_err),  64'(m_route));
        check({tag, ".idle"},   64'(idle),       64'(m_idle));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic tick_model(input string tag);
        model_step();
        @(posedge clk); #1;
        compare_model(tag);
    endtask

    task automatic clear_inputs();
        vld = 4'b0000;
        for (int c = 0; c < 4; c++) pld[c] = mk_pld(c, 0, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rdy = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("reset.en",     64'(ram_wr_en),  64'd0);
        check("reset.pld",    64'(ram_wr_pld), 64'd0);
        check("reset.credit", 64'(credit_ret), 64'd0);
        check("reset.ovf",    64'(ovf_err),    64'd0);
        check("reset.route",  64'(route_err),  64'd0);
        check("reset.idle",   64'(idle),       64'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] vld;
        logic       exp_en;
        int         exp_ch;
        int         exp_seq;
        logic [3:0] exp_credit;
        logic       exp_idle;
    } vec_t;

    vec_t tbl [9];
    int   writes;

    initial begin
        // Row r drives inputs for one cycle; expectations are the outputs
        // seen in the following cycle. Rows 0-5: all four channels at once
        // from ptr=0. Rows 6-8: single west command, two-cycle latency.
        tbl[0] = '{4'b1111, 1'b0, 0, 0, 4'b0000, 1'b0};
        tbl[1] = '{4'b0000, 1'b1, 0, 0, 4'b0001, 1'b0};
        tbl[2] = '{4'b0000, 1'b1, 1, 0, 4'b0010, 1'b0};
        tbl[3] = '{4'b0000, 1'b1, 2, 0, 4'b0100, 1'b0};
        tbl[4] = '{4'b0000, 1'b1, 3, 0, 4'b1000, 1'b0};
        tbl[5] = '{4'b0000, 1'b0, 0, 0, 4'b0000, 1'b1};
        tbl[6] = '{4'b0001, 1'b0, 0, 0, 4'b0000, 1'b0};
        tbl[7] = '{4'b0000, 1'b1, 0, 6, 4'b0001, 1'b0};
        tbl[8] = '{4'b0000, 1'b0, 0, 0, 4'b0000, 1'b1};

        do_reset();
        for (int r = 0; r < 9; r++) begin
            vld = tbl[r].vld;
            for (int c = 0; c < 4; c++) pld[c] = mk_pld(c, r, 0);
            tick();
            check($sformatf("tbl%0d.en", r),     64'(ram_wr_en),  64'(tbl[r].exp_en));
            check($sformatf("tbl%0d.credit", r), 64'(credit_ret), 64'(tbl[r].exp_credit));
            check($sformatf("tbl%0d.idle", r),   64'(idle),       64'(tbl[r].exp_idle));
            if (tbl[r].exp_en)
                check($sformatf("tbl%0d.pld", r), 64'(ram_wr_pld),
                      64'(mk_pld(tbl[r].exp_ch, tbl[r].exp_seq, 0)));
        end

        // ---- south fills while the port is blocked, then overflows ----
        do_reset();
        rdy = 1'b0;
        for (int s = 0; s < 6; s++) begin
            vld = 4'b0100;
            pld[2] = mk_pld(2, s, 0);
            tick_model($sformatf("fill%0d", s));
            if (s == 4) check("fill.no_ovf", 64'(ovf_err), 64'd0);
        end
        check("fill.ovf_south", 64'(ovf_err),    64'b0100);
        check("fill.head",      64'(ram_wr_pld), 64'(mk_pld(2, 0, 0)));
        clear_inputs();
        rdy = 1'b1;
        writes = 0;
        for (int k = 0; k < 7; k++) begin
            if (ram_wr_en && rdy) writes++;
            tick_model($sformatf("drain%0d", k));
        end
        check("drain.writes", 64'(writes), 64'd5);
        check("drain.idle",   64'(idle),   64'd1);

        // ---- stall in the middle of a stream ----
        do_reset();
        vld = 4'b1111;
        for (int c = 0; c < 4; c++) pld[c] = mk_pld(c, 40, 0);
        tick_model("stall.push");
        clear_inputs();
        tick_model("stall.west");
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick_model($sformatf("stall%0d", k));
            check("stall.pld_hold", 64'(ram_wr_pld), 64'(mk_pld(0, 40, 0)));
            check("stall.no_credit", 64'(credit_ret), 64'd0);
        end
        rdy = 1'b1;
        tick_model("stall.resume");
        check("stall.next_east", 64'(ram_wr_pld), 64'(mk_pld(1, 40, 0)));
        for (int k = 0; k < 3; k++) tick_model("stall.tail");

        // ---- misrouted north command ----
        do_reset();
        vld = 4'b1000;
        pld[3] = mk_pld(3, 9, 1);
        tick_model("route.hit");
        check("route.err",    64'(route_err),  64'd1);
        check("route.credit", 64'(credit_ret), 64'b1000);
        clear_inputs();
        tick_model("route.after");
        tick_model("route.after2");
        check("route.no_write", 64'(ram_wr_en), 64'd0);

        // ---- asynchronous reset with work in flight ----
        do_reset();
        rdy = 1'b0;
        vld = 4'b1111;
        for (int c = 0; c < 4; c++) pld[c] = mk_pld(c, 50, 0);
        tick_model("arst.push");
        clear_inputs();
        tick_model("arst.load");
        check("arst.busy", 64'(ram_wr_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.en",     64'(ram_wr_en),  64'd0);
        check("arst.pld",    64'(ram_wr_pld), 64'd0);
        check("arst.credit", 64'(credit_ret), 64'd0);
        check("arst.idle",   64'(idle),       64'd1);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) tick_model("arst.quiet");

        // ---- randomized traffic against the model ----
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 4; c++) begin
                vld[c] = ($urandom_range(0, 99) < 35);
                pld[c] = mk_pld(c, cyc, $urandom_range(0, 99) < 4);
            end
            rdy = ($urandom_range(0, 99) < 65);
            tick_model("rand");
        end
        clear_inputs();
        rdy = 1'b1;
        for (int k = 0; k < 20; k++) tick_model("rand.drain");
        check("rand.idle", 64'(idle), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_write_port_arb.md
Name: ram_write_port_arb

Overview:
- One instance per RAM bank (8 per direction group). Sits directly downstream of the write-command lane selector.
- Takes that bank's four valid-only write commands (west/east/south/north; south may carry linefill writes) and buffers each in a per-direction FIFO.
- Round-robin arbitrates one command per cycle onto the single RAM write port.
- Returns one credit per drained entry so upstream flow control never overruns the FIFOs.

Parameters:
FIFO_DEPTH, 4, entries per direction FIFO; power of 2, >=2.
RAM_PARITY, 0, expected value of dest_ram_id[0] for this bank (0 = even bank, 1 = odd bank).

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
west_wr_vld  input  1  west write command valid (no ready; single-cycle pulse per command)
west_wr_pld  input  write_ram_pld_t  west write command payload
east_wr_vld  input  1  east valid
east_wr_pld  input  write_ram_pld_t  east payload
south_wr_vld  input  1  south valid (linefill or south requester)
south_wr_pld  input  write_ram_pld_t  south payload
north_wr_vld  input  1  north valid
north_wr_pld  input  write_ram_pld_t  north payload
ram_wr_en  output  1  RAM write valid
ram_wr_pld  output  write_ram_pld_t  RAM write payload
ram_wr_ready  input  1  RAM accepts write this cycle (low during read/refresh conflict)
credit_ret  output  4  one-cycle credit pulse per channel; bit 0 = west, 1 = east, 2 = south, 3 = north
ovf_err  output  4  sticky: push while FIFO full; per channel
route_err  output  1  sticky: command with wrong bank parity received
idle  output  1  all FIFOs empty and output register empty

Behaviour:
Reset:
- ram_wr_en=0, ram_wr_pld=0, credit_ret=0, ovf_err=0, route_err=0, idle=1.
- FIFOs emptied; round-robin pointer = 0.
- Reset mid-operation discards all buffered and in-flight commands. No credits are returned for discarded entries.

Push (per channel, registered count):
- vld=1 and count<FIFO_DEPTH: enqueue payload.
- vld=1 and count==FIFO_DEPTH: drop the command and set ovf_err[ch]. This holds even if a pop occurs in the same cycle; full is evaluated on the pre-edge count.
- Push and pop in the same cycle on a non-full FIFO: count is unchanged.
- Parity check: if pld.write_cmd.req_cmd_pld.dest_ram_id[0] != RAM_PARITY, do not enqueue, set route_err, and pulse credit_ret[ch] the next cycle so upstream credit does not leak.

Output register (single stage, valid/ready):
- load_en = !ram_wr_en || ram_wr_ready.
- When load_en and any FIFO is non-empty: grant the lowest channel index at or after ptr (mod 4) among non-empty FIFOs. Pop it, load ram_wr_pld, set ram_wr_en=1, and set ptr = (grant+1) mod 4.
- When load_en and all FIFOs are empty: ram_wr_en=0 (ram_wr_pld holds its last value). ptr is unchanged.
- ram_wr_en=1 with ram_wr_ready=0: ram_wr_en and ram_wr_pld hold stable, no pop occurs, and ptr is frozen.

Credits and latency:
- credit_ret[ch] pulses for exactly one cycle, one cycle after the pop edge.
- Multiple channels never pulse together from pops, since there is at most one pop per cycle. A route-error credit may coincide with a pop credit on a different channel.
- Latency: a command presented in cycle t to an empty block with the port free appears with ram_wr_en=1 in cycle t+2. Its credit pulses in cycle t+2.
- Throughput: 1 write/cycle sustained while ram_wr_ready=1.

Ordering:
- FIFO order is preserved within a channel. There is no ordering guarantee across channels.

idle:
- Combinational: all counts 0 and !ram_wr_en.

Test Plan:
1. Single west command at cycle 10, ready=1 -> ram_wr_en=1 in cycle 12 with the same payload; credit_ret=4'b0001 in cycle 12; idle=1 from cycle 13.
2. All four channels push one command in the same cycle, ready=1, ptr=0 -> writes issued in order west, east, south, north on 4 consecutive cycles; credit_ret pulses 0001, 0010, 0100, 1000.
3. ready=0 for 6 cycles while south pushes 5 commands (FIFO_DEPTH=4) -> 1 command held in the output register, 4 queued, 0 dropped, ovf_err=0. A 6th push while full sets ovf_err[2]=1 and is dropped. Releasing ready drains 5 writes in order.
4. Stall mid-stream: ram_wr_en=1 with ready=0 for 3 cycles -> ram_wr_pld stable, no credit pulses, ptr unchanged; ready=1 resumes with the next channel in round-robin order.
5. RAM_PARITY=0, north command with dest_ram_id[0]=1 -> no RAM write, route_err=1, credit_ret[3] pulses the next cycle.
6. Assert rst with 3 entries queued and ram_wr_en=1 -> all outputs reach reset values asynchronously; no writes or credits follow the release of rst.
